// File: rtl/wave_table_loader.sv
// Writer side of the waveform BRAM: streams one digitized table into port A,
// accumulating a byte count and additive checksum and flagging malformed transfers.
module wave_table_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                TABLE_LEN = 1000,
  parameter logic [ADDR_W-1:0] SINE_BASE = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] TRI_BASE  = ADDR_W'(16'h03E8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        table_sel,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       checksum,
  output logic [15:0]       count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0]        ERR_NONE    = 2'd0;
  localparam logic [1:0]        ERR_BAD_SEL = 2'd1;
  localparam logic [1:0]        ERR_SHORT   = 2'd2;
  localparam logic [1:0]        ERR_LONG    = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(TABLE_LEN - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] index_r;
  logic [1:0]        pend_err_r;
  logic              accept_s;
  logic              at_end_s;

  // Termination status of a transfer given the final accepted byte.
  function automatic logic [1:0] end_code(input logic last, input logic at_end);
    logic [1:0] code;
    if (last && at_end) begin
      code = ERR_NONE;
    end else if (last) begin
      code = ERR_SHORT;
    end else begin
      code = ERR_LONG;
    end
    return code;
  endfunction

  assign accept_s = s_valid & s_ready;
  assign at_end_s = (index_r == LAST_IDX);

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= '0;
      index_r    <= '0;
      pend_err_r <= ERR_NONE;
      s_ready    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= 8'h00;
      bram_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      checksum   <= 16'h0000;
      count      <= 16'h0000;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            error    <= 1'b0;
            err_code <= ERR_NONE;
            checksum <= 16'h0000;
            count    <= 16'h0000;
            index_r  <= '0;
            case (table_sel)
              2'd0: begin
                base_r  <= SINE_BASE;
                state_r <= LOAD;
                busy    <= 1'b1;
                s_ready <= 1'b1;
              end
              2'd1: begin
                base_r  <= TRI_BASE;
                state_r <= LOAD;
                busy    <= 1'b1;
                s_ready <= 1'b1;
              end
              default: begin
                error    <= 1'b1;
                err_code <= ERR_BAD_SEL;
              end
            endcase
          end
        end
        LOAD: begin
          if (accept_s) begin
            bram_we   <= 1'b1;
            bram_addr <= base_r + index_r;
            bram_din  <= s_data;
            checksum  <= checksum + {8'h00, s_data};
            count     <= count + 16'd1;
            index_r   <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            // The terminating byte is still written; the stream closes right behind it.
            if (s_last || at_end_s) begin
              pend_err_r <= end_code(s_last, at_end_s);
              s_ready    <= 1'b0;
              state_r    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          if (pend_err_r == ERR_NONE) begin
            done <= 1'b1;
          end else begin
            error    <= 1'b1;
            err_code <= pend_err_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_table_loader.sv
// Randomized self-checking bench for wave_table_loader against a queue-based
// model of which bytes land where, with what totals and termination status.
module tb_wave_table_loader;

  localparam int TABLE_LEN = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  table_sel;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din;
  logic        bram_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] checksum;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic [7:0]  tx_data[$];
  logic        tx_last[$];
  logic [7:0]  st_data[$];
  logic        st_last[$];
  logic [23:0] got[$];
  logic [23:0] exp_w[$];
  logic [15:0] exp_sum;
  logic [15:0] exp_count;
  logic [1:0]  exp_err;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_acc_cyc = 0;
  int          got_base = 0;
  int          done_base = 0;
  bit          rand_start = 1'b0;

  wave_table_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .table_sel(table_sel),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .checksum(checksum), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Write and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bram_we === 1'b1) got.push_back({bram_addr, bram_din});
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Reference: bytes are taken in order until the first s_last or the table fills.
  function automatic void build_model(input logic [15:0] base);
    exp_w.delete();
    exp_sum   = 16'h0000;
    exp_count = 16'h0000;
    exp_err   = 2'd0;
    for (int i = 0; i < st_data.size(); i++) begin
      exp_w.push_back({base + 16'(i), st_data[i]});
      exp_sum   = exp_sum + {8'h00, st_data[i]};
      exp_count = exp_count + 16'd1;
      if (st_last[i]) begin
        exp_err = (i == TABLE_LEN - 1) ? 2'd0 : 2'd2;
        break;
      end
      if (i == TABLE_LEN - 1) begin
        exp_err = 2'd3;
        break;
      end
    end
  endfunction

  function automatic int write_mismatch();
    int n = got.size() - got_base;
    if (n != exp_w.size()) return (n < exp_w.size()) ? n : exp_w.size();
    for (int i = 0; i < n; i++) begin
      if (got[got_base + i] !== exp_w[i]) return i;
    end
    return -1;
  endfunction

  task automatic start_load(input logic [1:0] sel, input logic [15:0] base);
    st_data = tx_data;
    st_last = tx_last;
    build_model(base);
    got_base  = got.size();
    done_base = done_cnt;
    start     = 1'b1;
    table_sel = sel;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int bubble_pct, input int max_cycles, output int left);
    int n = 0;
    while (tx_data.size() > 0 && n < max_cycles) begin
      s_valid = (int'($urandom_range(99)) >= bubble_pct);
      s_data  = s_valid ? tx_data[0] : 8'($urandom);
      s_last  = s_valid ? tx_last[0] : 1'($urandom);
      if (rand_start) begin
        start     = ($urandom_range(15) == 0);
        table_sel = 2'($urandom);
      end
      if (s_valid && s_ready) begin
        void'(tx_data.pop_front());
        void'(tx_last.pop_front());
        last_acc_cyc = cyc + 32'd1;
      end
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    left    = tx_data.size();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; table_sel = 2'd0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, bram_addr, bram_din, bram_we, busy, done, error, err_code, checksum, count} !== 63'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b err=%b cnt=%0d sum=%h, expected all zero", busy, error, count, checksum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sine();
    int left, m;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < TABLE_LEN; i++) begin
      tx_data.push_back(8'(i));
      tx_last.push_back(i == TABLE_LEN - 1);
    end
    start_load(2'd0, 16'h0000);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || count !== 16'd0) begin
      failures++;
      $display("FAIL sine_start: got busy=%b s_ready=%b count=%0d, expected 1 1 0", busy, s_ready, count);
    end
    drive(0, 1100, left);
    repeat (4) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (left != 0 || m != -1) begin
      failures++;
      $display("FAIL sine_writes: got %0d writes (bad at %0d, %0d unsent), expected %0d", got.size() - got_base, m, left, exp_w.size());
    end
    checks++;
    if (done_cnt - done_base != 1 || done_cyc != last_acc_cyc + 32'd1) begin
      failures++;
      $display("FAIL sine_done: got %0d pulses at cycle %0d, expected 1 at %0d", done_cnt - done_base, done_cyc, last_acc_cyc + 32'd1);
    end
    checks++;
    if (count !== 16'd1000 || checksum !== 16'hE72C || checksum !== exp_sum) begin
      failures++;
      $display("FAIL sine_totals: got count=%0d sum=%h, expected 1000 e72c", count, checksum);
    end
    checks++;
    if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL sine_status: got err=%b code=%0d busy=%b rdy=%b, expected 0 0 0 0", error, err_code, busy, s_ready);
    end
  endtask

  task automatic test_triangle();
    int left, m;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < TABLE_LEN; i++) begin
      tx_data.push_back(8'hFF);
      tx_last.push_back(i == TABLE_LEN - 1);
    end
    start_load(2'd1, 16'h03E8);
    rand_start = 1'b1;
    drive(40, 5000, left);
    rand_start = 1'b0;
    repeat (4) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (left != 0 || m != -1) begin
      failures++;
      $display("FAIL tri_writes: got %0d writes (bad at %0d, %0d unsent), expected %0d", got.size() - got_base, m, left, exp_w.size());
    end
    checks++;
    if (count !== 16'd1000 || checksum !== 16'hE418) begin
      failures++;
      $display("FAIL tri_totals: got count=%0d sum=%h, expected 1000 e418", count, checksum);
    end
    checks++;
    if (done_cnt - done_base != 1 || error !== 1'b0) begin
      failures++;
      $display("FAIL tri_done: got %0d pulses err=%b, expected 1 pulse err=0", done_cnt - done_base, error);
    end
  endtask

  task automatic test_short();
    int left, m;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < 15; i++) begin
      tx_data.push_back(8'($urandom));
      tx_last.push_back(i == 9);
    end
    start_load(2'd0, 16'h0000);
    drive(20, 200, left);
    repeat (4) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (m != -1 || left != 5) begin
      failures++;
      $display("FAIL short_writes: got %0d writes (bad at %0d, %0d unsent), expected 10 writes 5 unsent", got.size() - got_base, m, left);
    end
    checks++;
    if (error !== 1'b1 || err_code !== 2'd2 || err_code !== exp_err) begin
      failures++;
      $display("FAIL short_err: got err=%b code=%0d, expected 1 2", error, err_code);
    end
    checks++;
    if (count !== 16'd10 || checksum !== exp_sum || done_cnt != done_base || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL short_totals: got count=%0d sum=%h done=%0d rdy=%b, expected 10 %h 0 0", count, checksum, done_cnt - done_base, s_ready, exp_sum);
    end
  endtask

  task automatic test_long();
    int left, m;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < TABLE_LEN + 1; i++) begin
      tx_data.push_back(8'($urandom));
      tx_last.push_back(1'b0);
    end
    start_load(2'd0, 16'h0000);
    drive(10, 1300, left);
    repeat (4) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (m != -1 || left != 1) begin
      failures++;
      $display("FAIL long_writes: got %0d writes (bad at %0d, %0d unsent), expected 1000 writes 1 unsent", got.size() - got_base, m, left);
    end
    checks++;
    if (error !== 1'b1 || err_code !== 2'd3 || count !== 16'd1000 || checksum !== exp_sum || done_cnt != done_base) begin
      failures++;
      $display("FAIL long_status: got err=%b code=%0d count=%0d done=%0d, expected 1 3 1000 0", error, err_code, count, done_cnt - done_base);
    end
  endtask

  task automatic test_bad_sel();
    int left;
    tx_data.delete(); tx_last.delete();
    start_load(2'd2, 16'h0000);
    checks++;
    if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || s_ready !== 1'b0 || count !== 16'd0) begin
      failures++;
      $display("FAIL badsel_status: got err=%b code=%0d busy=%b rdy=%b count=%0d, expected 1 1 0 0 0", error, err_code, busy, s_ready, count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got.size() != got_base || done_cnt != done_base) begin
      failures++;
      $display("FAIL badsel_nowrite: got %0d writes %0d done, expected 0 0", got.size() - got_base, done_cnt - done_base);
    end
    for (int i = 0; i < 3; i++) begin
      tx_data.push_back(8'($urandom));
      tx_last.push_back(i == 2);
    end
    start_load(2'd0, 16'h0000);
    checks++;
    if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL badsel_clear: got err=%b code=%0d busy=%b, expected 0 0 1", error, err_code, busy);
    end
    drive(0, 50, left);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    int left, m;
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < 500; i++) begin
      tx_data.push_back(8'($urandom));
      tx_last.push_back(1'b0);
    end
    start_load(2'd0, 16'h0000);
    drive(25, 1500, left);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    @(negedge clk);
    checks++;
    if ({s_ready, bram_addr, bram_din, bram_we, busy, done, error, err_code, checksum, count} !== 63'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b we=%b cnt=%0d sum=%h, expected all zero", busy, bram_we, count, checksum);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (m != -1 || left != 0) begin
      failures++;
      $display("FAIL midreset_writes: got %0d writes (bad at %0d), expected 500", got.size() - got_base, m);
    end
    tx_data.push_back(8'($urandom));
    tx_last.push_back(1'b1);
    start_load(2'd0, 16'h0000);
    drive(0, 20, left);
    repeat (4) @(negedge clk);
    m = write_mismatch();
    checks++;
    if (m != -1 || count !== 16'd1 || checksum !== exp_sum) begin
      failures++;
      $display("FAIL midreset_restart: got %0d writes (bad at %0d) count=%0d, expected 1 write at 0000 count=1", got.size() - got_base, m, count);
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_triangle();
    test_short();
    test_long();
    test_bad_sel();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_table_loader.md
Name: wave_table_loader

Overview:
- Writer side of the function generator's waveform BRAM: takes an 8-bit sample byte stream (valid/ready with last) and writes one complete digitized table into the BRAM write port.
- Two tables: sine at addresses 0x0000-0x03E7 and triangle at 0x03E8-0x07CF (1000 samples each).
- Reports completion, a 16-bit additive checksum and the byte count; flags malformed transfers.
- Sits between the host/UART byte path and BRAM port A; the generator reads on port B.

Parameters:
ADDR_W, 16, BRAM address width
TABLE_LEN, 1000, samples per table
SINE_BASE, 16'h0000, first address of the sine table
TRI_BASE, 16'h03E8, first address of the triangle table

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a load; sampled only in IDLE
table_sel  in  2  0=sine, 1=triangle, 2/3=invalid
s_valid  in  1  stream byte valid
s_data  in  8  stream byte
s_last  in  1  marks final byte of transfer
s_ready  out  1  loader accepts byte
bram_addr  out  ADDR_W  BRAM write address
bram_din  out  8  BRAM write data
bram_we  out  1  BRAM write enable
busy  out  1  load in progress
done  out  1  one-cycle pulse on successful load
error  out  1  sticky error flag
err_code  out  2  0=none, 1=BAD_SEL, 2=SHORT, 3=LONG
checksum  out  16  sum of accepted bytes mod 2^16
count  out  16  number of bytes accepted

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, index=0. Reset mid-load aborts immediately. No bram_we after the reset edge. No done or error is reported.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - s_ready=0.
  - start=1 at cycle S clears done, error, err_code, checksum and count at S+1.
  - table_sel 0/1: latch base (SINE_BASE/TRI_BASE), index=0, go to LOAD; busy=1 and s_ready=1 from S+1.
  - table_sel 2/3: stay IDLE; error=1, err_code=BAD_SEL at S+1; no writes.
- LOAD:
  - s_ready=1.
  - Handshake accept = s_valid & s_ready.
  - On accept at cycle N, registered at N+1: bram_we=1, bram_addr=base+index, bram_din=s_data, checksum+=s_data, count+=1, index+=1.
  - bram_we is 0 in every cycle with no accept at N-1. Bubbles are allowed; addresses stay contiguous.
  - Normal end: accept with index==TABLE_LEN-1 and s_last=1.
  - SHORT: accept with s_last=1 and index<TABLE_LEN-1.
  - LONG: accept with index==TABLE_LEN-1 and s_last=0.
  - In all three cases the byte is still written, s_ready=0 from N+1, and the FSM goes to FLUSH.
- FLUSH (cycle N+1, final write issued):
  - Next cycle (N+2): IDLE, busy=0.
  - Success: done=1 for exactly cycle N+2.
  - Failure: error=1 and err_code set at N+2; done stays 0.
  - Any bytes after a LONG error are not accepted (s_ready=0).
- start while busy is ignored.
- checksum, count, error and err_code hold until the next accepted start or reset.
- Address arithmetic is base+index in ADDR_W bits. With the default parameters the index never exceeds TABLE_LEN-1, so addresses never wrap.

Test Plan:
- Sine load: start, table_sel=0, 1000 bytes s_data=i mod 256, s_last on the 1000th byte.
  -> Writes to addr 0x0000..0x03E7 with matching data, in order.
  -> done pulse 2 cycles after the last handshake; count=1000, checksum=0xE72C, error=0.
- Triangle load: table_sel=1, 1000 bytes of 0xFF with s_valid toggled randomly (bubbles).
  -> Writes to 0x03E8..0x07CF, no write in bubble cycles.
  -> count=1000, checksum=0xE418.
- Short transfer: table_sel=0, s_last on the 10th byte.
  -> 10 writes (addr 0..9); s_ready=0 after.
  -> error=1, err_code=2, count=10, done never asserted.
- Long transfer: 1000 bytes without s_last, 1001st byte offered.
  -> 1000 writes; 1001st byte not accepted.
  -> err_code=3, count=1000.
- Bad select: start with table_sel=2.
  -> Next cycle error=1, err_code=1, busy=0, no bram_we.
  -> A following start with table_sel=0 clears error.
- Reset mid-load: rst_n=0 after 500 accepted bytes.
  -> Next cycle all outputs 0, no further bram_we.
  -> A new start then writes from addr 0x0000 with count restarting at 1.
